regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised multi-port integer register file for the core pipeline, next generation of the 2R/1W register file.
- Configurable width, depth, read-port and write-port count; register 0 hard-wired to zero; optional write-to-read bypass.
- Built-in scoreboard: per-register busy bit, set at issue and cleared at writeback, driving decode-stage RAW/WAW stalls.
- Sits between decode (reads, issue) and writeback (writes).

Parameters:
XLEN, 32, data width in bits
NREGS, 32, number of architectural registers; power of 2, at least 2
NREAD, 2, number of read ports
NWRITE, 1, number of write ports; 1..4
BYPASS, 1, 1 = same-cycle write data is forwarded to reads; 0 = reads return the pre-write value
AW, $clog2(NREGS), derived address width; not overridable

Ports:
clk  in  1  clock
rstn_i  in  1  asynchronous active-low reset
raddr_i  in  NREAD*AW  read addresses; port i occupies [i*AW +: AW]
rdata_o  out  NREAD*XLEN  read data, combinational
rbusy_o  out  NREAD  source register pending (RAW hazard) per read port
we_i  in  NWRITE  write enables
waddr_i  in  NWRITE*AW  write addresses
wdata_i  in  NWRITE*XLEN  write data
issue_i  in  1  decode issues an instruction writing issue_rd_i
issue_rd_i  in  AW  destination register of the issuing instruction
issue_ready_o  out  1  issue is accepted this cycle (no WAW conflict)
flush_i  in  1  pipeline flush; clears all busy bits
busy_o  out  NREGS  busy-bit vector, for debug and perf counters

Behaviour:
- Reset is asynchronous on rstn_i low: all registers go to 0 and all busy bits go to 0 immediately. While reset is held: rdata_o = 0, rbusy_o = 0, busy_o = 0, issue_ready_o = 1.
- Reset asserted mid-operation drops any in-flight write or issue. There is no partial update.
- Register 0:
  - Reads always return 0.
  - Writes to it are ignored.
  - Its busy bit is never set.
  - rbusy_o is 0 for address 0.
- Writes:
  - Take effect at the rising clk edge when we_i[j] = 1.
  - If several ports write the same address in one cycle, the highest-indexed port wins.
- Reads:
  - Combinational from stored state.
  - BYPASS = 1: if any enabled write port targets raddr (non-zero), rdata returns that port's wdata, with the highest index winning.
  - BYPASS = 0: reads return the stored value; the new value is visible from the next cycle.
- Busy bits, updated at the clk edge:
  - Clear: any enabled write to address r clears busy[r].
  - Set: issue_i && issue_ready_o && issue_rd_i != 0 sets busy[issue_rd_i].
  - A set and a clear on the same register in the same cycle leave it set, because the new producer wins.
  - flush_i = 1 clears all busy bits. It overrides an issue in the same cycle. Register writes in the flush cycle still commit.
- issue_ready_o = !busy[issue_rd_i] || (an enabled write to issue_rd_i this cycle) || issue_rd_i == 0. It is combinational.
- rbusy_o[i]:
  - BYPASS = 1: busy[raddr_i] && no enabled write to raddr_i this cycle.
  - BYPASS = 0: busy[raddr_i].
- Latency:
  - Write to visible read: 0 cycles with BYPASS = 1, 1 cycle with BYPASS = 0.
  - Issue to busy visible: 1 cycle.
- No X propagation: unused address bits do not exist because NREGS is a power of 2, and all storage is reset.

Decomposition:
- Package regfile_pkg:
  - Default XLEN/NREGS constants.
  - Function addr_width(n).
  - Typedef reg_addr_t for the AW-bit address.
- Sub-module regfile_scoreboard:
  - Owns the busy-bit array, set/clear/flush priority, issue_ready_o and the per-port busy lookup.
  - Parametrised by NREGS, NREAD, NWRITE, BYPASS.
  - regfile_mp holds data storage, bypass muxes and the instance.

Test Plan:
- Reset, then write 0xDEADBEEF to x5 on port 0 while reading x5 on port 0 -> rdata = 0xDEADBEEF in the same cycle (BYPASS = 1), 0 in that cycle with BYPASS = 0 and 0xDEADBEEF in the next cycle.
- Write 0xFFFFFFFF to x0, then read x0 on all ports -> 0. Issue rd = 0 -> busy_o stays 0 and issue_ready_o = 1.
- NWRITE = 2: port 0 writes 0x11 and port 1 writes 0x22 to x7 in the same cycle -> next-cycle read of x7 = 0x22.
- Issue rd = x3 -> next cycle busy_o[3] = 1 and rbusy for raddr x3 = 1. Issue x3 again -> issue_ready_o = 0. Write x3 in the same cycle -> issue_ready_o = 1 and busy_o[3] remains 1 after the edge.
- Issue x4, x9, x12 on consecutive cycles, then assert flush_i together with issue x6 and a write of 0x55 to x9 -> busy_o = 0 after the edge and x9 reads 0x55.
- Write 0x1234 to x8, then pulse rstn_i low asynchronously between clock edges -> rdata for x8 = 0 immediately; after release, busy_o = 0 and all registers read 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file.
package regfile_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned NREGS_DEF = 32;

  // Address width for a register file of n entries (n is a power of 2, >= 2).
  function automatic int unsigned addr_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  typedef logic [$clog2(NREGS_DEF)-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: tracks registers with an outstanding producer and
// flags RAW hazards per read port and WAW conflicts at issue.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned NREGS  = NREGS_DEF,
  parameter int unsigned NREAD  = 2,
  parameter int unsigned NWRITE = 1,
  parameter int unsigned BYPASS = 1,
  localparam int unsigned AW    = addr_width(NREGS)
) (
  input  logic              clk,
  input  logic              rstn_i,
  input  logic [NREAD*AW-1:0]  raddr_i,
  input  logic [NWRITE-1:0]    we_i,
  input  logic [NWRITE*AW-1:0] waddr_i,
  input  logic              issue_i,
  input  logic [AW-1:0]     issue_rd_i,
  input  logic              flush_i,
  output logic [NREAD-1:0]  rbusy_o,
  output logic              issue_ready_o,
  output logic [NREGS-1:0]  busy_o
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] wr_hit;
  logic [NREGS-1:0] set_vec;
  logic [AW-1:0]    ra;

  // Registers targeted by any enabled write port this cycle.
  always_comb begin
    wr_hit = '0;
    for (int unsigned j = 0; j < NWRITE; j++) begin
      if (we_i[j]) wr_hit[waddr_i[j*AW +: AW]] = 1'b1;
    end
  end

  assign issue_ready_o = !busy_q[issue_rd_i] || wr_hit[issue_rd_i] || (issue_rd_i == '0);

  // Busy bit to set for an accepted issue; x0 never becomes busy.
  always_comb begin
    set_vec = '0;
    if (issue_i && issue_ready_o && (issue_rd_i != '0)) set_vec[issue_rd_i] = 1'b1;
  end

  // Busy state: flush clears everything, otherwise a new producer outranks a writeback.
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      busy_q <= '0;
    end else if (flush_i) begin
      busy_q <= '0;
    end else begin
      busy_q <= (busy_q & ~wr_hit) | set_vec;
    end
  end

  // Per-port RAW hazard; a same-cycle write resolves it when data is bypassed.
  always_comb begin
    rbusy_o = '0;
    ra      = '0;
    for (int unsigned i = 0; i < NREAD; i++) begin
      ra         = raddr_i[i*AW +: AW];
      rbusy_o[i] = busy_q[ra] && !((BYPASS != 0) && wr_hit[ra]);
    end
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port integer register file with x0 hard-wired to zero,
// optional write-to-read bypass and an integrated busy-bit scoreboard.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN   = XLEN_DEF,
  parameter int unsigned NREGS  = NREGS_DEF,
  parameter int unsigned NREAD  = 2,
  parameter int unsigned NWRITE = 1,
  parameter int unsigned BYPASS = 1,
  localparam int unsigned AW    = addr_width(NREGS)
) (
  input  logic                   clk,
  input  logic                   rstn_i,
  input  logic [NREAD*AW-1:0]    raddr_i,
  output logic [NREAD*XLEN-1:0]  rdata_o,
  output logic [NREAD-1:0]       rbusy_o,
  input  logic [NWRITE-1:0]      we_i,
  input  logic [NWRITE*AW-1:0]   waddr_i,
  input  logic [NWRITE*XLEN-1:0] wdata_i,
  input  logic                   issue_i,
  input  logic [AW-1:0]          issue_rd_i,
  output logic                   issue_ready_o,
  input  logic                   flush_i,
  output logic [NREGS-1:0]       busy_o
);

  logic [XLEN-1:0] mem_q [NREGS];
  logic [AW-1:0]   ra;
  logic [XLEN-1:0] rd;

  // Register storage; later write ports overwrite earlier ones on a shared address.
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int unsigned r = 0; r < NREGS; r++) mem_q[r] <= '0;
    end else begin
      for (int unsigned j = 0; j < NWRITE; j++) begin
        if (we_i[j] && (waddr_i[j*AW +: AW] != '0))
          mem_q[waddr_i[j*AW +: AW]] <= wdata_i[j*XLEN +: XLEN];
      end
    end
  end

  // Read muxes: stored value, optionally overridden by same-cycle write data.
  // Reset is folded in so a held reset hides bypassed write data as well.
  always_comb begin
    rdata_o = '0;
    ra      = '0;
    rd      = '0;
    for (int unsigned i = 0; i < NREAD; i++) begin
      ra = raddr_i[i*AW +: AW];
      rd = mem_q[ra];
      if (BYPASS != 0) begin
        for (int unsigned j = 0; j < NWRITE; j++) begin
          if (we_i[j] && (waddr_i[j*AW +: AW] == ra)) rd = wdata_i[j*XLEN +: XLEN];
        end
      end
      if ((ra == '0) || !rstn_i) rd = '0;
      rdata_o[i*XLEN +: XLEN] = rd;
    end
  end

  regfile_scoreboard #(
    .NREGS  (NREGS),
    .NREAD  (NREAD),
    .NWRITE (NWRITE),
    .BYPASS (BYPASS)
  ) u_scoreboard (
    .clk           (clk),
    .rstn_i        (rstn_i),
    .raddr_i       (raddr_i),
    .we_i          (we_i),
    .waddr_i       (waddr_i),
    .issue_i       (issue_i),
    .issue_rd_i    (issue_rd_i),
    .flush_i       (flush_i),
    .rbusy_o       (rbusy_o),
    .issue_ready_o (issue_ready_o),
    .busy_o        (busy_o)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: a bypassing and a non-bypassing instance
// share stimulus and are compared against an array-based reference model.
module tb_regfile_mp;

  localparam int NR = 2;
  localparam int NW = 2;
  localparam int AW = 5;
  localparam int XL = 32;
  localparam int N  = 32;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic [NR*AW-1:0]  raddr = '0;
  logic [NW-1:0]     we = '0;
  logic [NW*AW-1:0]  waddr = '0;
  logic [NW*XL-1:0]  wdata = '0;
  logic              issue = 1'b0;
  logic [AW-1:0]     issue_rd = '0;
  logic              flush = 1'b0;

  logic [NR*XL-1:0]  rdata_a, rdata_b;
  logic [NR-1:0]     rbusy_a, rbusy_b;
  logic              ready_a, ready_b;
  logic [N-1:0]      busy_a, busy_b;

  // Reference model state
  logic [XL-1:0]     mem_m [N];
  logic [N-1:0]      busy_m;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_mp #(.XLEN(XL), .NREGS(N), .NREAD(NR), .NWRITE(NW), .BYPASS(1)) dut_byp (
    .clk(clk), .rstn_i(rstn), .raddr_i(raddr), .rdata_o(rdata_a), .rbusy_o(rbusy_a),
    .we_i(we), .waddr_i(waddr), .wdata_i(wdata), .issue_i(issue), .issue_rd_i(issue_rd),
    .issue_ready_o(ready_a), .flush_i(flush), .busy_o(busy_a));

  regfile_mp #(.XLEN(XL), .NREGS(N), .NREAD(NR), .NWRITE(NW), .BYPASS(0)) dut_nobyp (
    .clk(clk), .rstn_i(rstn), .raddr_i(raddr), .rdata_o(rdata_b), .rbusy_o(rbusy_b),
    .we_i(we), .waddr_i(waddr), .wdata_i(wdata), .issue_i(issue), .issue_rd_i(issue_rd),
    .issue_ready_o(ready_b), .flush_i(flush), .busy_o(busy_b));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Which registers receive an enabled write this cycle
  function automatic logic [N-1:0] hits();
    logic [N-1:0] h = '0;
    for (int j = 0; j < NW; j++)
      if (we[j]) h[waddr[j*AW +: AW]] = 1'b1;
    return h;
  endfunction

  function automatic logic [XL-1:0] m_read(input int a, input bit byp);
    if (a == 0) return '0;
    if (byp)
      for (int j = NW - 1; j >= 0; j--)
        if (we[j] && int'(waddr[j*AW +: AW]) == a) return wdata[j*XL +: XL];
    return mem_m[a];
  endfunction

  function automatic bit m_ready();
    logic [N-1:0] h = hits();
    return (issue_rd == '0) || !busy_m[issue_rd] || h[issue_rd];
  endfunction

  task automatic model_reset();
    for (int r = 0; r < N; r++) mem_m[r] = '0;
    busy_m = '0;
  endtask

  // Compare all combinational outputs at the negedge against the model.
  task automatic sample();
    logic [N-1:0] h;
    int a;
    @(negedge clk);
    h = hits();
    for (int i = 0; i < NR; i++) begin
      a = int'(raddr[i*AW +: AW]);
      chk("rdata_byp",   64'(rdata_a[i*XL +: XL]), 64'(m_read(a, 1'b1)));
      chk("rdata_nobyp", 64'(rdata_b[i*XL +: XL]), 64'(m_read(a, 1'b0)));
      chk("rbusy_byp",   64'(rbusy_a[i]), 64'(busy_m[a] && !h[a]));
      chk("rbusy_nobyp", 64'(rbusy_b[i]), 64'(busy_m[a]));
    end
    chk("ready_byp",   64'(ready_a), 64'(m_ready()));
    chk("ready_nobyp", 64'(ready_b), 64'(m_ready()));
    chk("busy_byp",    64'(busy_a), 64'(busy_m));
    chk("busy_nobyp",  64'(busy_b), 64'(busy_m));
  endtask

  // Advance the model across the rising edge using the inputs applied this cycle.
  task automatic commit();
    logic [N-1:0] h;
    bit rdy;
    @(posedge clk);
    h   = hits();
    rdy = m_ready();
    for (int j = 0; j < NW; j++)
      if (we[j] && waddr[j*AW +: AW] != '0) mem_m[waddr[j*AW +: AW]] = wdata[j*XL +: XL];
    if (flush) busy_m = '0;
    else begin
      busy_m = busy_m & ~h;
      if (issue && rdy && issue_rd != '0) busy_m[issue_rd] = 1'b1;
    end
    #1;
  endtask

  task automatic idle();
    we = '0; issue = 1'b0; flush = 1'b0;
  endtask

  task automatic step();
    sample();
    commit();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    model_reset();
    #12;
    chk("reset_rdata", 64'(rdata_a), 64'(0));
    chk("reset_busy",  64'(busy_a), 64'(0));
    chk("reset_ready", 64'(ready_a), 64'(1));
    @(posedge clk); #1;
    rstn = 1'b1;

    // Bypass vs non-bypass visibility of a fresh write
    raddr = {5'd0, 5'd5}; we = 2'b01; waddr = {5'd0, 5'd5}; wdata = {32'h0, 32'hDEADBEEF};
    sample();
    chk("byp_same_cycle",   64'(rdata_a[31:0]), 64'(32'hDEADBEEF));
    chk("nobyp_same_cycle", 64'(rdata_b[31:0]), 64'(0));
    commit();
    idle();
    sample();
    chk("nobyp_next_cycle", 64'(rdata_b[31:0]), 64'(32'hDEADBEEF));
    commit();

    // x0 is immutable and never busy
    we = 2'b01; waddr = {5'd0, 5'd0}; wdata = {32'h0, 32'hFFFFFFFF};
    step();
    idle(); raddr = '0; issue = 1'b1; issue_rd = 5'd0;
    sample();
    chk("x0_ready", 64'(ready_a), 64'(1));
    chk("x0_read",  64'(rdata_b), 64'(0));
    commit();
    idle();
    sample();
    chk("x0_busy", 64'(busy_a), 64'(0));
    commit();

    // Two ports writing the same register: highest index wins
    we = 2'b11; waddr = {5'd7, 5'd7}; wdata = {32'h22, 32'h11};
    raddr = {5'd0, 5'd7};
    sample();
    chk("dual_write_byp", 64'(rdata_a[31:0]), 64'(32'h22));
    commit();
    idle();
    sample();
    chk("dual_write_next", 64'(rdata_b[31:0]), 64'(32'h22));
    commit();

    // Issue/WAW interplay on x3
    issue = 1'b1; issue_rd = 5'd3;
    step();
    issue = 1'b0; raddr = {5'd0, 5'd3};
    sample();
    chk("x3_busy",  64'(busy_a[3]), 64'(1));
    chk("x3_rbusy", 64'(rbusy_b[0]), 64'(1));
    commit();
    issue = 1'b1; issue_rd = 5'd3;
    sample();
    chk("x3_waw_stall", 64'(ready_a), 64'(0));
    commit();
    we = 2'b01; waddr = {5'd0, 5'd3}; wdata = {32'h0, 32'h33};
    sample();
    chk("x3_ready_with_wb", 64'(ready_a), 64'(1));
    commit();
    idle();
    sample();
    chk("x3_still_busy", 64'(busy_b[3]), 64'(1));
    commit();

    // Flush overrides an issue; writes in the flush cycle still commit
    issue = 1'b1; issue_rd = 5'd4;  step();
    issue_rd = 5'd9;                step();
    issue_rd = 5'd12;               step();
    issue_rd = 5'd6; flush = 1'b1; we = 2'b01; waddr = {5'd0, 5'd9}; wdata = {32'h0, 32'h55};
    step();
    idle(); raddr = {5'd0, 5'd9};
    sample();
    chk("flush_busy",  64'(busy_a), 64'(0));
    chk("flush_write", 64'(rdata_b[31:0]), 64'(32'h55));
    commit();

    // Randomized traffic, addresses concentrated to provoke collisions
    for (int c = 0; c < 400; c++) begin
      raddr    = {5'($urandom_range(0, 11)), 5'($urandom_range(0, 11))};
      we       = 2'($urandom);
      waddr    = {5'($urandom_range(0, 11)), 5'($urandom_range(0, 11))};
      wdata    = {$urandom, $urandom};
      issue    = 1'($urandom);
      issue_rd = 5'($urandom_range(0, 11));
      flush    = ($urandom_range(0, 15) == 0);
      step();
    end

    // Asynchronous reset between edges drops in-flight write/issue
    idle();
    we = 2'b01; waddr = {5'd0, 5'd8}; wdata = {32'h0, 32'h1234};
    step();
    idle(); raddr = {5'd8, 5'd8};
    sample();
    chk("pre_reset_x8", 64'(rdata_b[31:0]), 64'(32'h1234));
    #1 rstn = 1'b0;
    we = 2'b10; waddr = {5'd8, 5'd0}; wdata = {32'hAAAA, 32'h0};
    issue = 1'b1; issue_rd = 5'd8;
    #1;
    chk("async_rdata_byp",   64'(rdata_a), 64'(0));
    chk("async_rdata_nobyp", 64'(rdata_b), 64'(0));
    chk("async_busy",        64'(busy_a), 64'(0));
    chk("async_ready",       64'(ready_b), 64'(1));
    @(posedge clk); #1;
    chk("held_reset_rdata", 64'(rdata_a), 64'(0));
    chk("held_reset_busy",  64'(busy_b), 64'(0));
    model_reset();
    idle();
    rstn = 1'b1;
    for (int r = 0; r < N; r += 2) begin
      raddr = {5'(r + 1), 5'(r)};
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
